prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a header byte N (0 = 256) then N big-endian 16-bit words and writes them to instruction ROM
// from address 0, holding the CPU in reset until the load completes. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_HI, S_LO, S_WR, S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  n_q, n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        xfer;

    assign xfer      = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        count_d     = count_q;
        n_d         = n_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_HDR;
                    in_ready_d = 1'b1;
                    mem_addr_d = 8'd0;
                    count_d    = 9'd0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d     = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    mem_wdata_d[15:8] = in_data;
                    state_d           = S_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d            = csum_q ^ in_data;
`endif
                end
            end
            S_LO: begin
                if (xfer) begin
                    mem_wdata_d[7:0] = in_data;
                    state_d          = S_WR;
                    in_ready_d       = 1'b0;
                    mem_we_d         = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d           = csum_q ^ in_data;
`endif
                end
            end
            S_WR: begin
                // 8-bit address wraps 255->0 after the 256th word.
                mem_addr_d = mem_addr_q + 8'd1;
                count_d    = count_q + 9'd1;
                if (count_q + 9'd1 == n_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d    = S_CHK;
                    in_ready_d = 1'b1;
`else
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
`endif
                end else begin
                    state_d    = S_HI;
                    in_ready_d = 1'b1;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d    = S_DONE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    if (in_data == csum_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        error_d    = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                cpu_hold_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 16'd0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= 9'd0;
            n_q         <= 9'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            count_q     <= count_d;
            n_q         <= n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end
endmodule
